// File: rtl/ts_packet_scheduler.sv
// Rate-paced two-source TS packet scheduler: a phase accumulator paces byte
// requests, packet slots are granted round-robin, returned bytes are merged.
module ts_packet_scheduler #(
   parameter int ACC_WIDTH = 24,
   parameter int PKT_BYTES = 204
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iEnable,
   input  logic [ACC_WIDTH-1:0] iRateStep,
   input  logic [1:0]           iPktRdy,
   input  logic [1:0]           iValid,
   input  logic [7:0]           iData0,
   input  logic [7:0]           iData1,
   input  logic [1:0]           iPSync,
   output logic [1:0]           oReq,
   output logic [7:0]           oData,
   output logic                 oValid,
   output logic                 oPSync,
   output logic                 oSel,
   output logic                 oOverrun,
   output logic [15:0]          oPktCnt0,
   output logic [15:0]          oPktCnt1
);

   localparam int CW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_pend;
   logic [CW-1:0]        r_cnt;
   logic                 r_grant;

   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_tick;
   logic                 w_issue;
   logic                 w_last;
   logic                 w_grant;

   always_ff @(posedge iClk) begin
      if (iRst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = iEnable ? ARB : IDLE;
         ARB:     w_next = SEND;
         SEND:    if (w_last) w_next = iEnable ? ARB : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Neither source ready keeps the old grant so that source emits null packets.
   always_comb begin
      w_sum   = {1'b0, r_acc} + {1'b0, iRateStep};
      w_tick  = w_sum[ACC_WIDTH] && (r_state != IDLE);
      w_issue = (r_state == SEND) && (w_tick || r_pend);
      w_last  = w_issue && (r_cnt == CW'(PKT_BYTES - 1));
      w_grant = r_grant;
      case (iPktRdy)
         2'b01:   w_grant = 1'b0;
         2'b10:   w_grant = 1'b1;
         2'b11:   w_grant = ~r_grant;
         default: w_grant = r_grant;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_acc    <= '0;
         r_pend   <= 1'b0;
         r_cnt    <= '0;
         r_grant  <= 1'b0;
         oReq     <= 2'b00;
         oOverrun <= 1'b0;
         oPktCnt0 <= 16'd0;
         oPktCnt1 <= 16'd0;
      end else begin
         r_acc <= (r_state == IDLE) ? '0 : w_sum[ACC_WIDTH-1:0];
         if (r_state == IDLE || w_issue) r_pend <= 1'b0;
         else if (w_tick)                r_pend <= 1'b1;
         if (w_issue) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
         oReq <= w_issue ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
         if (r_state == ARB) begin
            r_grant <= w_grant;
            if (w_grant) oPktCnt1 <= oPktCnt1 + 16'd1;
            else         oPktCnt0 <= oPktCnt0 + 16'd1;
         end
         if ((w_tick && r_pend && !w_issue) || (&iValid))
            oOverrun <= 1'b1;
      end
   end

   // Source 0 has priority when both return a byte in the same cycle.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oValid <= 1'b0;
         oData  <= 8'd0;
         oPSync <= 1'b0;
         oSel   <= 1'b0;
      end else begin
         oValid <= |iValid;
         oData  <= iValid[0] ? iData0 : iData1;
         oPSync <= iValid[0] ? iPSync[0] : iPSync[1];
         oSel   <= ~iValid[0];
      end
   end

endmodule

// File: tb/tb_ts_packet_scheduler.sv
// Directed bench for ts_packet_scheduler: a byte-source responder feeds a
// scoreboard of merged bytes while a monitor tracks request pacing and slots.
module tb_ts_packet_scheduler;

   localparam int AW = 24;
   localparam int PB = 204;

   logic          iClk = 1'b0;
   logic          iRst = 1'b1;
   logic          iEnable = 1'b0;
   logic [AW-1:0] iRateStep = '0;
   logic [1:0]    iPktRdy = 2'b00;
   logic [1:0]    iValid = 2'b00;
   logic [7:0]    iData0 = 8'd0;
   logic [7:0]    iData1 = 8'd0;
   logic [1:0]    iPSync = 2'b00;
   logic [1:0]    oReq;
   logic [7:0]    oData;
   logic          oValid;
   logic          oPSync;
   logic          oSel;
   logic          oOverrun;
   logic [15:0]   oPktCnt0;
   logic [15:0]   oPktCnt1;

   ts_packet_scheduler #(.ACC_WIDTH(AW), .PKT_BYTES(PB)) dut (
      .iClk(iClk), .iRst(iRst), .iEnable(iEnable),
      .iRateStep(iRateStep), .iPktRdy(iPktRdy), .iValid(iValid),
      .iData0(iData0), .iData1(iData1), .iPSync(iPSync),
      .oReq(oReq), .oData(oData), .oValid(oValid), .oPSync(oPSync),
      .oSel(oSel), .oOverrun(oOverrun),
      .oPktCnt0(oPktCnt0), .oPktCnt1(oPktCnt1)
   );

   always #5 iClk = ~iClk;

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       p;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Byte source: answers each request one cycle later and records the byte.
   logic       resp_en = 1'b1;
   logic [1:0] pend = 2'b00;
   logic [7:0] cnt0 = 8'd0;
   logic [7:0] cnt1 = 8'd0;

   always @(posedge iClk) begin
      #1;
      if (iRst) begin
         pend   = 2'b00;
         iValid = 2'b00;
         sbq.delete();
      end else if (resp_en) begin
         iValid = pend;
         pend   = oReq;
         if (iValid[0]) begin
            iData0    = cnt0;
            iPSync[0] = 1'($urandom_range(1, 0));
            cnt0      = cnt0 + 8'd1;
            sbq.push_back('{d: iData0, s: 1'b0, p: iPSync[0]});
         end
         if (iValid[1]) begin
            iData1    = ~cnt1;
            iPSync[1] = 1'($urandom_range(1, 0));
            cnt1      = cnt1 + 8'd1;
            sbq.push_back('{d: iData1, s: 1'b1, p: iPSync[1]});
         end
      end
   end

   always @(negedge iClk) begin
      exp_t e;
      if (oValid) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected", 32'(oValid), 32'(0));
         end else begin
            e = sbq.pop_front();
            chk("sb_data", 32'(oData), 32'(e.d));
            chk("sb_sel", 32'(oSel), 32'(e.s));
            chk("sb_psync", 32'(oPSync), 32'(e.p));
         end
      end
   end

   // Request monitor: pacing intervals and per-slot source.
   int cyc = 0;
   int tot = 0;
   int prev = 0;
   int have_prev = 0;
   int min_iv = 1000000;
   int max_iv = 0;
   int n_iv2 = 0;
   int mixed = 0;
   int both = 0;
   int slot_src[$];

   always @(negedge iClk) begin
      int iv;
      int src;
      cyc++;
      if (oReq != 2'b00) begin
         if (oReq == 2'b11) both++;
         src = int'(oReq[1]);
         if (have_prev != 0) begin
            iv = cyc - prev;
            if (iv < min_iv) min_iv = iv;
            if (iv > max_iv) max_iv = iv;
            if (iv == 2) n_iv2++;
         end
         prev = cyc;
         have_prev = 1;
         if (tot % PB == 0) slot_src.push_back(src);
         else if (slot_src.size() > 0 && slot_src[$] != src) mixed++;
         tot++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iClk);
         #2;
      end
   endtask

   task automatic clr_mon();
      tot = 0;
      have_prev = 0;
      min_iv = 1000000;
      max_iv = 0;
      n_iv2 = 0;
      mixed = 0;
      both = 0;
      slot_src.delete();
   endtask

   task automatic wait_tot(input string tag, input int n, input int budget);
      int k = 0;
      while (tot < n && k < budget) begin
         tick(1);
         k++;
      end
      chk(tag, 32'(tot >= n), 32'(1));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_oReq"}, 32'(oReq), 32'(0));
      chk({tag, "_oValid"}, 32'(oValid), 32'(0));
      chk({tag, "_oData"}, 32'(oData), 32'(0));
      chk({tag, "_oPSync"}, 32'(oPSync), 32'(0));
      chk({tag, "_oSel"}, 32'(oSel), 32'(0));
      chk({tag, "_oOverrun"}, 32'(oOverrun), 32'(0));
      chk({tag, "_cnt0"}, 32'(oPktCnt0), 32'(0));
      chk({tag, "_cnt1"}, 32'(oPktCnt1), 32'(0));
   endtask

   initial begin
      int exp_slots[9] = '{0, 0, 0, 1, 0, 1, 0, 0, 0};

      iRst = 1'b1;
      tick(3);
      chk_reset_outs("rst");

      // Half rate, only source 0 ready.
      iRst = 1'b0;
      clr_mon();
      iRateStep = 24'h800000;
      iPktRdy = 2'b01;
      iEnable = 1'b1;
      wait_tot("first_req", 1, 50);
      chk("cnt0_slot1", 32'(oPktCnt0), 32'(1));
      wait_tot("slot2", PB + 1, 1000);
      chk("cnt0_slot2", 32'(oPktCnt0), 32'(2));
      chk("cnt1_slot2", 32'(oPktCnt1), 32'(0));

      // Both ready, then none ready.
      wait_tot("slot3", 2 * PB + 10, 1000);
      iPktRdy = 2'b11;
      wait_tot("slot7", 6 * PB + 10, 4000);
      iPktRdy = 2'b00;
      wait_tot("slot9", 8 * PB + 10, 2000);
      chk("slot_count", 32'(slot_src.size()), 32'(9));
      for (int i = 0; i < 9; i++)
         if (i < slot_src.size())
            chk($sformatf("slot_src%0d", i), 32'(slot_src[i]),
                32'(exp_slots[i]));
      chk("cnt0_rr", 32'(oPktCnt0), 32'(7));
      chk("cnt1_rr", 32'(oPktCnt1), 32'(2));
      chk("half_min_iv", 32'(min_iv), 32'(2));
      chk("half_max_iv", 32'(max_iv), 32'(2));
      chk("slot_mixed", 32'(mixed), 32'(0));
      chk("req_onehot", 32'(both), 32'(0));
      chk("ovr_half", 32'(oOverrun), 32'(0));

      // Reset in the middle of a slot.
      wait_tot("byte100", 8 * PB + 100, 1000);
      iRst = 1'b1;
      iPktRdy = 2'b11;
      tick(1);
      chk_reset_outs("midrst");
      iRst = 1'b0;
      clr_mon();

      // Restart with both ready, then drop enable at byte 50 of slot 2.
      wait_tot("restart_b50", PB + 50, 1500);
      iEnable = 1'b0;
      tick(500);
      chk("drop_tot", 32'(tot), 32'(2 * PB));
      chk("restart_src0", 32'(slot_src[0]), 32'(1));
      chk("restart_src1", 32'(slot_src[1]), 32'(0));
      chk("drop_cnt0", 32'(oPktCnt0), 32'(1));
      chk("drop_cnt1", 32'(oPktCnt1), 32'(1));
      tick(200);
      chk("idle_noreq", 32'(tot), 32'(2 * PB));

      // Zero rate: a slot is granted but nothing is requested.
      iRateStep = '0;
      iPktRdy = 2'b01;
      iEnable = 1'b1;
      clr_mon();
      tick(300);
      chk("zero_rate_tot", 32'(tot), 32'(0));
      chk("zero_rate_cnt0", 32'(oPktCnt0), 32'(2));

      // Maximum rate: back-to-back requests, tick in ARB carried over.
      iRst = 1'b1;
      tick(1);
      iRst = 1'b0;
      iRateStep = 24'hFFFFFF;
      clr_mon();
      wait_tot("max_slot4", 3 * PB + 5, 1000);
      chk("max_min_iv", 32'(min_iv), 32'(1));
      chk("max_max_iv", 32'(max_iv), 32'(2));
      chk("max_gaps", 32'(n_iv2), 32'(3));
      chk("max_cnt0", 32'(oPktCnt0), 32'(4));
      chk("ovr_max", 32'(oOverrun), 32'(0));
      iEnable = 1'b0;
      tick(300);
      chk("sb_drain", 32'(sbq.size()), 32'(0));

      // Simultaneous returns: source 0 wins and overrun latches.
      resp_en = 1'b0;
      chk("ovr_before", 32'(oOverrun), 32'(0));
      iValid = 2'b11;
      iData0 = 8'hA5;
      iData1 = 8'h3C;
      iPSync = 2'b10;
      sbq.push_back('{d: 8'hA5, s: 1'b0, p: 1'b0});
      tick(1);
      iValid = 2'b00;
      tick(1);
      chk("ovr_both", 32'(oOverrun), 32'(1));
      chk("ovr_drain", 32'(sbq.size()), 32'(0));
      tick(2);
      chk("ovr_sticky", 32'(oOverrun), 32'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ts_packet_scheduler.md
TS_PACKET_SCHEDULER -- requirements
Module: ts_packet_scheduler

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 24: width of the rate-phase accumulator.
REQ-002 SHALL have parameter PKT_BYTES, default 204: byte requests per scheduled packet slot.
REQ-003 SHALL have port iClk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port iRst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port iEnable  input  1: scheduler run enable.
REQ-006 SHALL have port iRateStep  input  ACC_WIDTH: phase increment per clock; byte-rate = fclk*iRateStep/2^ACC_WIDTH.
REQ-007 SHALL have port iPktRdy  input  2: per-source flag, at least PKT_BYTES buffered.
REQ-008 SHALL have port iValid  input  2: per-source byte valid, returned 1 cycle after that source's oReq.
REQ-009 SHALL have ports iData0, iData1  input  8: per-source byte.
REQ-010 SHALL have port iPSync  input  2: per-source packet-start flag, aligned with iValid.
REQ-011 SHALL have port oReq  output  2: per-source one-cycle byte request.
REQ-012 SHALL have ports oData  output  8, oValid  output  1, oPSync  output  1: merged byte stream.
REQ-013 SHALL have port oSel  output  1: source index of the current oData byte.
REQ-014 SHALL have port oOverrun  output  1: sticky flag, rate tick lost.
REQ-015 SHALL have ports oPktCnt0, oPktCnt1  output  16: slots granted per source, wrapping.

Function
REQ-016 SHALL implement FSM states IDLE, ARB, SEND.
REQ-017 IDLE: accumulator held at 0, pending cleared, no oReq; go to ARB when iEnable=1.
REQ-018 ARB: lasts exactly 1 cycle; grant chosen; go to SEND; increment oPktCnt of the granted source (mod 2^16).
REQ-019 Grant rule: if exactly one iPktRdy bit is set, grant that source; if both are set, grant the source not granted last (round-robin); if neither is set, hold the previous grant (the source emits null packets).
REQ-020 Grant after reset SHALL be source 0, and it SHALL be the "last granted" for round-robin.
REQ-021 Outside IDLE, each cycle: {carry,acc} = acc + iRateStep, ACC_WIDTH+1-bit sum; carry = tick.
REQ-022 In SEND, issue = tick OR pending; on issue, oReq[grant] SHALL be 1 on the next cycle for exactly one cycle, pending cleared, byte counter +1.
REQ-023 Tick in ARB SHALL set pending; tick while pending already set and no issue that cycle SHALL set oOverrun.
REQ-024 Byte counter SHALL run 0..PKT_BYTES-1; on the issue with counter = PKT_BYTES-1 it SHALL clear to 0 and the FSM SHALL enter ARB (iEnable=1) or IDLE (iEnable=0).
REQ-025 iEnable deassertion mid-SEND SHALL NOT truncate the packet; the slot completes first.
REQ-026 Merge: oValid <= |iValid; oData/oPSync <= source 0 values if iValid[0], else source 1 values; oSel <= !iValid[0]; 1-cycle register.
REQ-027 With both iValid high, source 0 SHALL win and oOverrun SHALL be set.
REQ-028 Total latency: issue cycle -> oReq +1 -> iValid +2 -> oValid +3.
REQ-029 iRateStep=0 SHALL produce no requests; its maximum value SHALL produce a tick every cycle except the first.

Reset
REQ-030 With iRst=1 at a clock edge: FSM=IDLE, acc=0, pending=0, byte counter=0, grant=0.
REQ-031 With iRst=1 at a clock edge: oReq=0, oValid=0, oData=0, oPSync=0, oSel=0, oOverrun=0, oPktCnt0=oPktCnt1=0.
REQ-032 Reset mid-SEND SHALL abandon the slot; no oReq the cycle after reset.

Verification
REQ-033 ACC_WIDTH=24, iRateStep=2^23, iPktRdy=01, iEnable=1 -> oReq[0] every 2nd cycle, 204 pulses, ARB, repeat; oPktCnt0 +1 per slot.
REQ-034 iPktRdy=11 held -> grants alternate 1,0,1,0 (first slot source 1); oSel follows.
REQ-035 iPktRdy=00 -> grant stays 0; requests continue at the same rate.
REQ-036 iRateStep=2^24-1 -> tick in ARB sets pending, served first cycle of SEND; oOverrun stays 0.
REQ-037 iEnable dropped at byte 50 -> remaining 154 requests issued, then IDLE, no further oReq.
REQ-038 iRst pulsed at byte 100 -> all outputs at reset values next cycle; restart gives grant from source 0 rules, byte counter 0.
